// File: rtl/sar_search4.sv
// sar_search4 - successive-approximation search controller.
//
// Drives trial values onto the B input of an external combinational magnitude
// comparator and reads back its flags to resolve the unknown value on the A
// input, MSB first. One decision is made per clock while in TEST.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   begin a search; only sampled in IDLE
//   gtA     in   comparator flag: A > guess
//   gtB     in   comparator flag: guess > A
//   AeqB    in   comparator flag: A == guess
//   guess   out  trial value presented to comparator B
//   busy    out  high while in TEST or DONE
//   done    out  one-cycle pulse; result/hit/err valid
//   result  out  resolved value, held until the next accepted start
//   hit     out  search ended on an exact AeqB match
//   err     out  comparator flags were not one-hot; search aborted
module sar_search4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             gtA,
  input  logic             gtB,
  input  logic             AeqB,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             hit,
  output logic             err
);

  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StTest = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [WIDTH-1:0] Lsb = WIDTH'(1);
  localparam logic [WIDTH-1:0] Msb = Lsb << (WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             hit_q, hit_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] idx_bit;
  logic [WIDTH-1:0] acc_next;
  logic             flags_onehot;

  // Bit currently under trial.
  assign idx_bit = Lsb << idx_q;

  // Exactly one of the three flags set: odd parity rules out 0 and 2 set,
  // the AND term rules out all three.
  assign flags_onehot = (gtA ^ gtB ^ AeqB) & ~(gtA & gtB & AeqB);

  // gtA: target is above the guess, so the trial bit belongs in the answer.
  // gtB: target is below, so the trial bit is dropped. The guess already
  // holds acc | idx_bit, so it is the accumulator candidate directly.
  assign acc_next = gtA ? guess_q : (guess_q & ~idx_bit);

  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;
    hit_d    = hit_q;
    err_d    = err_q;

    case (state_q)
      StIdle: begin
        guess_d = '0;
        if (start) begin
          acc_d   = '0;
          idx_d   = IdxW'(WIDTH - 1);
          guess_d = Msb;
          hit_d   = 1'b0;
          err_d   = 1'b0;
          state_d = StTest;
        end
      end

      StTest: begin
        if (!flags_onehot) begin
          err_d    = 1'b1;
          result_d = '0;
          hit_d    = 1'b0;
          guess_d  = '0;
          state_d  = StDone;
        end else if (AeqB) begin
          result_d = guess_q;
          hit_d    = 1'b1;
          guess_d  = '0;
          state_d  = StDone;
        end else begin
          acc_d = acc_next;
          if (idx_q == '0) begin
            // All bits decided without an exact match.
            result_d = acc_next;
            hit_d    = 1'b0;
            guess_d  = '0;
            state_d  = StDone;
          end else begin
            idx_d   = idx_q - IdxW'(1);
            guess_d = acc_next | (idx_bit >> 1);
          end
        end
      end

      StDone: begin
        guess_d = '0;
        state_d = StIdle;
      end

      default: begin
        guess_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      guess_q  <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      hit_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      hit_q    <= hit_d;
      err_q    <= err_d;
    end
  end

  assign guess  = guess_q;
  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign hit    = hit_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search4.sv
// Directed bench for sar_search4 (WIDTH=4). A behavioural comparator answers
// the DUT guesses against a bench-held target; force_bad makes the flags
// non-one-hot on a chosen trial.
module tb_sar_search4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       gtA;
  logic       gtB;
  logic       AeqB;
  logic [3:0] guess;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       hit;
  logic       err;

  logic [3:0] target;
  logic       force_bad;

  int n_checks;
  int n_fails;

  sar_search4 #(
    .WIDTH(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .gtA   (gtA),
    .gtB   (gtB),
    .AeqB  (AeqB),
    .guess (guess),
    .busy  (busy),
    .done  (done),
    .result(result),
    .hit   (hit),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    gtA  = force_bad | (target > guess);
    gtB  = force_bad | (guess > target);
    AeqB = ~force_bad & (target == guess);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one search from IDLE. Start is applied on a falling edge (cycle 0);
  // done is expected in cycle trials+1. gseq holds expected guesses, trial 1
  // in the low nibble; chk_guess=0 skips the per-trial guess checks. bad_at
  // selects the trial on which the flags are corrupted (0 = never). poke
  // holds start high throughout the search to show it is ignored.
  task automatic search(input string tag, input logic [3:0] tgt, input int trials,
                        input logic [15:0] gseq, input bit chk_guess, input logic [3:0] exp_res,
                        input logic exp_hit, input logic exp_err, input int bad_at,
                        input bit poke);
    int cyc;
    target = tgt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = poke;
    cyc = 1;
    while (!done && cyc < 12) begin
      force_bad = (cyc == bad_at);
      if (chk_guess && cyc <= trials) begin
        check({tag, "_guess"}, 32'(guess), 32'(gseq[(cyc-1)*4 +: 4]));
      end
      @(negedge clk);
      force_bad = 1'b0;
      cyc++;
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(trials + 1));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_hit"}, 32'(hit), 32'(exp_hit));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_held"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    int tr;
    int lsb;
    n_checks  = 0;
    n_fails   = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    target    = 4'd0;
    force_bad = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_guess", 32'(guess), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    // 1. target 11: 8 (gtA), 12 (gtB), 10 (gtA), 11 (AeqB).
    search("t11", 4'd11, 4, 16'hBAC8, 1'b1, 4'd11, 1'b1, 1'b0, 0, 1'b0);
    // 2. target 0: 8, 4, 2, 1 all gtB.
    search("t0", 4'd0, 4, 16'h1248, 1'b1, 4'd0, 1'b0, 1'b0, 0, 1'b0);
    // 3. target 8: exact on the first trial.
    search("t8", 4'd8, 1, 16'h0008, 1'b1, 4'd8, 1'b1, 1'b0, 0, 1'b0);
    // 4. target 15: 8, 12, 14, 15 with AeqB on the last.
    search("t15", 4'd15, 4, 16'hFEC8, 1'b1, 4'd15, 1'b1, 1'b0, 0, 1'b0);

    // Sweep: hit unless target 0; trials = 4 minus the lowest set bit index.
    for (int t = 0; t < 16; t++) begin
      lsb = 0;
      for (int b = 3; b >= 0; b--) begin
        if (t[b]) lsb = b;
      end
      tr = (t == 0) ? 4 : 4 - lsb;
      search($sformatf("sweep%0d", t), 4'(t), tr, 16'h0, 1'b0, 4'(t), (t != 0), 1'b0, 0,
             1'b0);
    end

    // 5. corrupted flags on trial 2: abort with err.
    search("err", 4'd11, 2, 16'h00C8, 1'b1, 4'd0, 1'b0, 1'b1, 2, 1'b0);

    // 6a. start held high during a search is ignored.
    search("poke", 4'd11, 4, 16'hBAC8, 1'b1, 4'd11, 1'b1, 1'b0, 0, 1'b1);

    // 6b. asynchronous reset in the middle of the third trial.
    target = 4'd11;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_guess3", 32'(guess), 32'd10);
    #1 rst_n = 1'b0;
    #1;
    check("arst_guess", 32'(guess), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_result", 32'(result), 32'd0);
    check("arst_hit", 32'(hit), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    #1 rst_n = 1'b1;
    search("restart", 4'd11, 4, 16'hBAC8, 1'b1, 4'd11, 1'b1, 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
